// File: rtl/at86rf215_iq_deframer_if.sv
// rtl/at86rf215_iq_deframer_if.sv - bit-pair input and framed I/Q word output bundle
// master drives the LVDS bit pairs and enable; slave is the deframer.
interface at86rf215_iq_deframer_if #(
  parameter int ERR_W = 16
);
  logic             enable;
  logic             rx_bit_rise;
  logic             rx_bit_fall;
  logic [31:0]      iq_word_out;
  logic             word_valid_out;
  logic [12:0]      i_data;
  logic [12:0]      q_data;
  logic             locked;
  logic [ERR_W-1:0] sync_err_cnt;

  modport master (
    output enable, rx_bit_rise, rx_bit_fall,
    input  iq_word_out, word_valid_out, i_data, q_data, locked, sync_err_cnt
  );

  modport slave (
    input  enable, rx_bit_rise, rx_bit_fall,
    output iq_word_out, word_valid_out, i_data, q_data, locked, sync_err_cnt
  );
endinterface

// File: rtl/at86rf215_iq_deframer.sv
// rtl/at86rf215_iq_deframer.sv - AT86RF215 LVDS I/Q bitstream word framer
// Hunts for I_SYNC/Q_SYNC at either bit parity, qualifies lock, emits one word per 16 clk.
module at86rf215_iq_deframer #(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2,
  parameter int ERR_W      = 16
) (
  input logic                    clk,
  input logic                    reset,
  at86rf215_iq_deframer_if.slave bus
);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(MISS_LIMIT);

  state_t           state;
  logic [32:0]      sr;
  logic [3:0]       phase;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;
  logic             align_b;
  logic [31:0]      iq_word;
  logic             word_valid;
  logic             locked_q;
  logic [ERR_W-1:0] err_cnt;

  logic [31:0] cand_a;
  logic [31:0] cand_b;
  logic [31:0] cand_sel;
  logic        match_a;
  logic        match_b;
  logic        match_sel;
  logic        boundary;

  function automatic logic is_sync(input logic [31:0] c);
    return (c[31:30] == 2'b10) && (c[15:14] == 2'b01);
  endfunction

  // A: word ends on a fall bit; B: word ends on a rise bit (one bit older).
  assign cand_a    = sr[31:0];
  assign cand_b    = sr[32:1];
  assign cand_sel  = align_b ? cand_b : cand_a;
  assign match_a   = is_sync(cand_a);
  assign match_b   = is_sync(cand_b);
  assign match_sel = is_sync(cand_sel);
  assign boundary  = (phase == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      sr         <= '0;
      phase      <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      align_b    <= 1'b0;
      iq_word    <= '0;
      word_valid <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      sr         <= {sr[30:0], bus.rx_bit_rise, bus.rx_bit_fall};
      word_valid <= 1'b0;
      phase      <= phase + 4'd1;
      if (!bus.enable) begin
        state     <= HUNT;
        phase     <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
        locked_q  <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (match_a || match_b) begin
              align_b   <= !match_a;
              phase     <= '0;
              match_cnt <= 4'd1;
              miss_cnt  <= '0;
              if (LOCK_N == 4'd1) begin
                state      <= LOCKED;
                locked_q   <= 1'b1;
                word_valid <= 1'b1;
                iq_word    <= match_a ? cand_a : cand_b;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (boundary) begin
              if (match_sel) begin
                if (match_cnt + 4'd1 == LOCK_N) begin
                  state      <= LOCKED;
                  locked_q   <= 1'b1;
                  word_valid <= 1'b1;
                  iq_word    <= cand_sel;
                  miss_cnt   <= '0;
                end else begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else begin
                state     <= HUNT;
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (match_sel) begin
                word_valid <= 1'b1;
                iq_word    <= cand_sel;
                miss_cnt   <= '0;
              end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (miss_cnt + 4'd1 == MISS_N) begin
                  state     <= HUNT;
                  locked_q  <= 1'b0;
                  miss_cnt  <= '0;
                  match_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + 4'd1;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.iq_word_out    = iq_word;
  assign bus.word_valid_out = word_valid;
  assign bus.i_data         = iq_word[29:17];
  assign bus.q_data         = iq_word[13:1];
  assign bus.locked         = locked_q;
  assign bus.sync_err_cnt   = err_cnt;

endmodule

// File: tb/tb_at86rf215_iq_deframer.sv
// tb/tb_at86rf215_iq_deframer.sv - directed scoreboard bench for at86rf215_iq_deframer
// Expected words are queued as they are driven and popped on each word_valid_out pulse.
module tb_at86rf215_iq_deframer;

  localparam logic [31:0] W_A5  = 32'hA5A55A5A;
  localparam logic [31:0] W_ODD = 32'h80014000;
  localparam logic [31:0] W_S   = 32'h80004000;
  localparam logic [31:0] W_C   = 32'h00004000;
  localparam logic [31:0] W_Z   = 32'h00000000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  at86rf215_iq_deframer_if #(.ERR_W(16)) bus ();

  at86rf215_iq_deframer #(
    .LOCK_COUNT(3),
    .MISS_LIMIT(2),
    .ERR_W     (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;
  int          last_cyc = 0;
  bit          have_last = 1'b0;
  bit          saw_locked = 1'b0;
  bit          pend_v = 1'b0;
  logic        pend_b = 1'b0;
  logic [31:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 every cycle; checks any pulse against the scoreboard.
  task automatic sample();
    logic [31:0] e;
    cyc_n++;
    if (bus.locked === 1'b1) saw_locked = 1'b1;
    if (bus.word_valid_out === 1'b1) begin
      chk("pulse_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("iq_word", bus.iq_word_out, e);
        chk("i_data", 32'(bus.i_data), 32'(e[29:17]));
        chk("q_data", 32'(bus.q_data), 32'(e[13:1]));
      end
      if (have_last)
        chk("pulse_spacing", 32'(((cyc_n - last_cyc) % 16 == 0) && (cyc_n - last_cyc >= 16)), 32'd1);
      last_cyc  = cyc_n;
      have_last = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic drive_bit(input logic b);
    if (!pend_v) begin
      pend_b = b;
      pend_v = 1'b1;
    end else begin
      bus.rx_bit_rise = pend_b;
      bus.rx_bit_fall = b;
      pend_v = 1'b0;
      step();
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit emit);
    if (emit) expq.push_back(w);
    send_bits(w, 31, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_bit_rise = pend_v ? pend_b : 1'b0;
      bus.rx_bit_fall = 1'b0;
      pend_v = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    bus.enable      = 1'b1;
    bus.rx_bit_rise = 1'b0;
    bus.rx_bit_fall = 1'b0;
    pend_v     = 1'b0;
    have_last  = 1'b0;
    saw_locked = 1'b0;
    expq.delete();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.rx_bit_rise = 1'b0;
    bus.rx_bit_fall = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_iq_word", bus.iq_word_out, 32'h0);
    chk("reset_valid", 32'(bus.word_valid_out), 32'h0);
    chk("reset_locked", 32'(bus.locked), 32'h0);
    chk("reset_err", 32'(bus.sync_err_cnt), 32'h0);
    chk("reset_i_data", 32'(bus.i_data), 32'h0);
    chk("reset_q_data", 32'(bus.q_data), 32'h0);

    // Even alignment, first emit on the third boundary.
    do_reset();
    send_word(W_A5, 1'b0);
    send_word(W_A5, 1'b0);
    chk("t1_locked_before", 32'(bus.locked), 32'h0);
    send_word(W_A5, 1'b1);
    send_word(W_A5, 1'b1);
    send_word(W_A5, 1'b1);
    tick(2);
    chk("t1_locked", 32'(bus.locked), 32'h1);
    chk("t1_iq_word", bus.iq_word_out, 32'hA5A55A5A);
    chk("t1_i_data", 32'(bus.i_data), 32'h12D2);
    chk("t1_q_data", 32'(bus.q_data), 32'h0D2D);
    chk("t1_err", 32'(bus.sync_err_cnt), 32'h0);
    chk("t1_drained", 32'(expq.size()), 32'h0);

    // Odd alignment through candidate B.
    do_reset();
    drive_bit(1'b0);
    send_word(W_ODD, 1'b0);
    send_word(W_ODD, 1'b0);
    send_word(W_ODD, 1'b1);
    send_word(W_ODD, 1'b1);
    tick(3);
    chk("t2_locked", 32'(bus.locked), 32'h1);
    chk("t2_iq_word", bus.iq_word_out, 32'h80014000);
    chk("t2_i_data", 32'(bus.i_data), 32'h0);
    chk("t2_q_data", 32'(bus.q_data), 32'h0);
    chk("t2_drained", 32'(expq.size()), 32'h0);

    // Single corrupted word while locked.
    do_reset();
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    send_word(W_C, 1'b0);
    send_word(W_S, 1'b1);
    chk("t3_locked_after_miss", 32'(bus.locked), 32'h1);
    chk("t3_err", 32'(bus.sync_err_cnt), 32'h1);
    send_word(W_S, 1'b1);
    tick(2);
    chk("t3_drained", 32'(expq.size()), 32'h0);

    // Two consecutive misses drop lock; three good words relock.
    do_reset();
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    send_word(W_C, 1'b0);
    send_word(W_C, 1'b0);
    chk("t4_locked_one_miss", 32'(bus.locked), 32'h1);
    chk("t4_err_one_miss", 32'(bus.sync_err_cnt), 32'h1);
    send_word(W_S, 1'b0);
    chk("t4_unlocked", 32'(bus.locked), 32'h0);
    chk("t4_err_two_miss", 32'(bus.sync_err_cnt), 32'h2);
    have_last = 1'b0;
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    tick(2);
    chk("t4_relocked", 32'(bus.locked), 32'h1);
    chk("t4_err_final", 32'(bus.sync_err_cnt), 32'h2);
    chk("t4_drained", 32'(expq.size()), 32'h0);

    // False sync in HUNT.
    do_reset();
    send_word(W_S, 1'b0);
    for (int i = 0; i < 4; i++) send_word(W_Z, 1'b0);
    chk("t5_locked", 32'(bus.locked), 32'h0);
    chk("t5_never_locked", 32'(saw_locked), 32'h0);
    chk("t5_drained", 32'(expq.size()), 32'h0);

    // Asynchronous reset mid-word while locked.
    do_reset();
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    send_bits(W_S, 31, 16);
    chk("t6_locked_pre", 32'(bus.locked), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_iq_word", bus.iq_word_out, 32'h0);
    chk("t6_rst_locked", 32'(bus.locked), 32'h0);
    chk("t6_rst_valid", 32'(bus.word_valid_out), 32'h0);
    chk("t6_rst_i_data", 32'(bus.i_data), 32'h0);
    do_reset();
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    tick(2);
    chk("t6_relocked", 32'(bus.locked), 32'h1);
    chk("t6_drained", 32'(expq.size()), 32'h0);

    // Enable dropped mid-word while locked, then requalification.
    do_reset();
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    send_bits(W_S, 31, 16);
    bus.enable = 1'b0;
    have_last  = 1'b0;
    send_bits(W_S, 15, 14);
    chk("t7_locked_off", 32'(bus.locked), 32'h0);
    chk("t7_valid_off", 32'(bus.word_valid_out), 32'h0);
    send_bits(W_S, 13, 0);
    send_word(W_S, 1'b0);
    send_word(W_Z, 1'b0);
    chk("t7_err_kept", 32'(bus.sync_err_cnt), 32'h0);
    bus.enable = 1'b1;
    send_word(W_S, 1'b0);
    send_word(W_S, 1'b0);
    chk("t7_not_yet_locked", 32'(bus.locked), 32'h0);
    send_word(W_S, 1'b1);
    send_word(W_S, 1'b1);
    tick(2);
    chk("t7_relocked", 32'(bus.locked), 32'h1);
    chk("t7_drained", 32'(expq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/at86rf215_iq_deframer.md
Name: at86rf215_iq_deframer

Overview:
- Frames the AT86RF215 LVDS I/Q bitstream into aligned 32-bit I/Q words.
- Input: two bits per clk, pre-captured from the DDR receiver (rise bit first, fall bit second).
- Hunts for I_SYNC/Q_SYNC, qualifies the lock, then emits one word plus a 1-cycle valid pulse every 16 clk.
- Sits directly upstream of the Avalon-ST I/Q source stage, which consumes iq_word_out/word_valid_out.

Parameters:
- LOCK_COUNT, 3, consecutive sync matches at a fixed alignment needed to enter LOCKED (1..15)
- MISS_LIMIT, 2, consecutive sync misses in LOCKED that force a return to HUNT (1..15)
- ERR_W, 16, width of the saturating sync-error counter

Ports:
- clk  in  1  delayedCLK, 64 MHz, DDR bit clock domain
- reset  in  1  asynchronous, active-high
- enable  in  1  deframer enable; low forces HUNT and suppresses output
- rx_bit_rise  in  1  bit captured on rising edge (earlier bit in time)
- rx_bit_fall  in  1  bit captured on falling edge (later bit in time)
- iq_word_out  out  32  framed word, first received bit at [31]
- word_valid_out  out  1  one-cycle pulse when iq_word_out is new
- i_data  out  13  iq_word_out[29:17]
- q_data  out  13  iq_word_out[13:1]
- locked  out  1  high while state is LOCKED
- sync_err_cnt  out  ERR_W  saturating count of sync misses in LOCKED

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0; state HUNT; shift register, counters and alignment 0.
- Shift register: 33 bits; each clk, sr <= {sr[30:0], rx_bit_rise, rx_bit_fall}.
- Candidates (on updated sr): A = sr[31:0] (word ends on a fall bit); B = sr[32:1] (word ends on a rise bit).
- Sync match: cand[31:30]==2'b10 AND cand[15:14]==2'b01. Control bits [16] and [0] are ignored.
- Phase counter: 4 bits, counts 0..15, wraps 15->0. A word boundary occurs when phase==15.
- HUNT:
  - Candidates are checked every cycle.
  - On a match: latch alignment (A wins if both match), phase<=0, match_cnt<=1, go to CONFIRM.
  - If LOCK_COUNT==1, go directly to LOCKED instead and emit that word.
- CONFIRM:
  - At each boundary, check the latched candidate.
  - Match: match_cnt++. When it reaches LOCK_COUNT, go to LOCKED and emit that word.
  - Miss: go to HUNT.
  - No words are emitted in CONFIRM.
- LOCKED, at each boundary:
  - Match: iq_word_out <= candidate, word_valid_out pulses, miss_cnt <= 0.
  - Miss: no emit; iq_word_out holds its previous value; miss_cnt++; sync_err_cnt++ (saturates at all-ones). When miss_cnt reaches MISS_LIMIT, go to HUNT and miss_cnt <= 0.
  - Between boundaries, word_valid_out = 0.
- Latency: word_valid_out/iq_word_out are registered. They assert on the clk edge after the edge that shifted in the word's last bit.
- Output rate when locked: exactly one pulse per 16 clk, never back-to-back.
- i_data/q_data are combinational slices of the registered iq_word_out.
- locked: registered, equal to (state==LOCKED).
- enable low, any state: next state HUNT, no emit, counters cleared. The shift register keeps shifting.
- enable rising: hunting restarts from HUNT the next cycle.
- sync_err_cnt is cleared only by reset.
- Reset mid-word: immediate return to reset values; no partial word is emitted after reset.
- No backpressure: the downstream stage must accept a word within 16 clk.

Test Plan:
- Aligned stream, even alignment: repeat 0xA5A55A5A MSB-first, enable=1 -> locked=1 and the first word_valid_out after the 3rd boundary. Then one pulse per 16 clk with iq_word_out=0xA5A55A5A, i_data=13'h12D2, q_data=13'h0D2D.
- Odd alignment: stream 0x80014000 preceded by a single padding bit -> lock via candidate B. Outputs are 0x80014000, i_data=13'h0000, q_data=13'h0000.
- Single corrupted word while locked (sync bits [31:30] forced to 2'b00 on one word) -> no pulse at that boundary, locked stays 1, sync_err_cnt=1, next word emitted normally.
- Two consecutive corrupted words -> after the 2nd miss, locked=0 and sync_err_cnt=2. Relocks after 3 good words.
- False sync in HUNT: one matching pattern followed by a non-matching word 16 clk later -> returns to HUNT, locked never asserts, no pulses.
- Reset or enable=0 asserted mid-word while locked -> all outputs 0 / locked=0 immediately (reset) or next cycle (enable). No word_valid_out until full requalification.
